// File: rtl/rf_wb_arbiter.sv
// Generic FIFO: DEPTH entries of W bits, registered pointers and occupancy count.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: full refuses pushes even while a pop happens in the same cycle.
module rf_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Register-file write-port arbiter between ALU writeback and buffered load returns.
// Latency: ALU accept -> write next cycle; load accept -> write two cycles later at best.
// Backpressure: alu_ready drops for one forced-load cycle after STARVE_LIM wins; lsu_ready = !full.
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd_addr,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic            issue_is_load,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     busy,
    output logic            rf_w_en,
    output logic [4:0]      rf_rda,
    output logic [XLEN-1:0] rf_rd
);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] dat;
    } ld_ent_t;

    ld_ent_t       push_ent;
    ld_ent_t       head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;
    logic [31:0]   busy_q;
    logic [31:0]   busy_nxt;
    logic          force_ld;
    logic          alu_acc;
    logic          lsu_acc;
    logic          ld_pop;

    // Readies come from state only; rst_n gating keeps them low while in reset.
    assign force_ld  = !fifo_empty && (starve_cnt == LIM);
    assign alu_ready = rst_n && !force_ld;
    assign lsu_ready = rst_n && !fifo_full;
    assign alu_acc   = alu_valid && alu_ready;
    assign lsu_acc   = lsu_valid && lsu_ready;
    assign ld_pop    = !alu_acc && !fifo_empty;
    assign push_ent  = '{rd: lsu_rd_addr, dat: lsu_data};
    assign busy      = busy_q;

    rf_wb_fifo #(
        .W     ($bits(ld_ent_t)),
        .DEPTH (DEPTH)
    ) u_ld_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (lsu_acc),
        .push_dat (push_ent),
        .pop      (ld_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        starve_nxt = '0;
        if (alu_acc && !fifo_empty)
            starve_nxt = (starve_cnt == LIM) ? LIM : starve_cnt + 1'b1;
    end

    // Clear on commit first, then set on issue, so a same-edge set wins.
    always_comb begin
        busy_nxt = busy_q;
        if (ld_pop)
            busy_nxt[head.rd] = 1'b0;
        if (issue_valid && issue_is_load)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            busy_q     <= '0;
            rf_w_en    <= 1'b0;
            rf_rda     <= '0;
            rf_rd      <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            busy_q     <= busy_nxt;
            if (alu_acc) begin
                rf_w_en <= (alu_rd_addr != 5'd0);
                rf_rda  <= alu_rd_addr;
                rf_rd   <= alu_data;
            end else if (ld_pop) begin
                rf_w_en <= (head.rd != 5'd0);
                rf_rda  <= head.rd;
                rf_rd   <= head.dat;
            end else begin
                rf_w_en <= 1'b0;
            end
        end
    end

    // Decode must never issue a second load to a register still waiting on one.
    a_one_load_per_rd: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_valid && issue_is_load && (issue_rd != 5'd0) && busy_q[issue_rd]));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a queue-based transaction model.
module tb_rf_wb_arbiter;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0, issue_is_load = 1'b0;
    logic [4:0]  alu_rd_addr = '0, lsu_rd_addr = '0, issue_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, rf_w_en;
    logic [4:0]  rf_rda;
    logic [31:0] rf_rd, busy;

    rf_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .busy(busy), .rf_w_en(rf_w_en), .rf_rda(rf_rda), .rf_rd(rf_rd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: load FIFO as a queue, starvation as an integer count.
    typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    int          m_starve;
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_rda;
    logic [31:0] m_rd;
    logic        obs_alu_rdy, obs_lsu_rdy, last_alu_acc, last_lsu_acc;

    task automatic model_reset();
        mq.delete();
        m_starve = 0; m_busy = '0; m_wen = 1'b0; m_rda = '0; m_rd = '0;
        last_alu_acc = 1'b0; last_lsu_acc = 1'b0;
    endtask

    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iv, input logic il, input logic [4:0] ird);
        logic ea, el, ne;
        ent_t e;
        @(negedge clk);
        chk("rf_w_en", rf_w_en, m_wen);
        chk("rf_rda", rf_rda, m_rda);
        chk("rf_rd", rf_rd, m_rd);
        chk("busy", busy, m_busy);
        ne = (mq.size() > 0);
        ea = !(ne && m_starve == LIM);
        el = (mq.size() < DEPTH);
        chk("alu_ready", alu_ready, ea);
        chk("lsu_ready", lsu_ready, el);
        obs_alu_rdy = alu_ready;
        obs_lsu_rdy = lsu_ready;
        alu_valid = av; alu_rd_addr = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd_addr = lrd; lsu_data = ld;
        issue_valid = iv; issue_is_load = il; issue_rd = ird;
        last_alu_acc = av && ea;
        last_lsu_acc = lv && el;
        if (last_alu_acc) begin
            m_wen = (ard != 0); m_rda = ard; m_rd = ad;
            m_starve = ne ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        end else if (ne) begin
            e = mq.pop_front();
            m_wen = (e.rd != 0); m_rda = e.rd; m_rd = e.d;
            if (e.rd != 0) m_busy[e.rd] = 1'b0;
            m_starve = 0;
        end else begin
            m_wen = 1'b0;
            m_starve = 0;
        end
        if (last_lsu_acc) mq.push_back('{rd: lrd, d: ld});
        if (iv && il && ird != 0) m_busy[ird] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wins;
        logic [31:0] adat;
        logic pa_v, pl_v, iv, il;
        logic [4:0] pa_rd, pl_rd, ird;
        logic [31:0] pa_d, pl_d;
        logic [4:0] outq[$];
        int idx, apct;

        #1 rst_n = 1'b0;
        #11;
        chk("rst_w_en", rf_w_en, 0);
        chk("rst_rda", rf_rda, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();

        // 1: single ALU writeback
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        chk("t1_accept", obs_alu_rdy, 1);
        @(posedge clk); #1;
        chk("t1_w_en", rf_w_en, 1);
        chk("t1_rda", rf_rda, 5);
        chk("t1_rd", rf_rd, 32'hDEADBEEF);

        // 2: load to x7 through the FIFO, busy set then cleared on commit
        step(0, 0, 0, 0, 0, 0, 1, 1, 7);
        @(posedge clk); #1;
        chk("t2_busy_set", busy[7], 1);
        step(0, 0, 0, 1, 7, 32'h1234, 0, 0, 0);
        @(posedge clk); #1;
        chk("t2_no_bypass", rf_w_en, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t2_w_en", rf_w_en, 1);
        chk("t2_rda", rf_rda, 7);
        chk("t2_rd", rf_rd, 32'h1234);
        chk("t2_busy_clr", busy[7], 0);
        idle(2);

        // 3: starvation limit forces one load through
        step(0, 0, 0, 0, 0, 0, 1, 1, 9);
        adat = 32'h100;
        step(1, 3, adat, 1, 9, 32'h9999, 0, 0, 0);
        adat++;
        wins = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 3, adat, 0, 0, 0, 0, 0, 0);
            if (!obs_alu_rdy) break;
            wins++;
            adat++;
        end
        chk("t3_wins", wins, LIM);
        @(posedge clk); #1;
        chk("t3_forced_rda", rf_rda, 9);
        chk("t3_forced_w_en", rf_w_en, 1);
        step(1, 3, adat, 0, 0, 0, 0, 0, 0);
        chk("t3_restart", obs_alu_rdy, 1);
        idle(2);

        // 4: fill the FIFO under ALU pressure, then drain in order
        step(0, 0, 0, 0, 0, 0, 1, 1, 10);
        step(0, 0, 0, 0, 0, 0, 1, 1, 11);
        step(1, 1, 32'hA1, 1, 10, 32'hB10, 0, 0, 0);
        step(1, 2, 32'hA2, 1, 11, 32'hB11, 0, 0, 0);
        step(1, 4, 32'hA3, 0, 0, 0, 0, 0, 0);
        chk("t4_full", obs_lsu_rdy, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t4_first", rf_rda, 10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t4_second", rf_rda, 11);
        chk("t4_second_dat", rf_rd, 32'hB11);
        idle(2);

        // 5: writes to x0 are consumed silently
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 32'h55, 1, 0, 32'h66, 0, 0, 0);
        @(posedge clk); #1;
        chk("t5_alu_x0", rf_w_en, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t5_ld_x0", rf_w_en, 0);
        chk("t5_busy0", busy[0], 0);
        idle(2);

        // 6: async reset with two queued loads and busy = 0x80
        step(1, 1, 32'h1, 0, 0, 0, 1, 1, 7);
        step(1, 2, 32'h2, 1, 0, 32'hC1, 0, 0, 0);
        step(1, 3, 32'h3, 1, 0, 32'hC2, 0, 0, 0);
        @(posedge clk); #2;
        chk("t6_pre_busy", busy, 32'h80);
        alu_valid = 0; lsu_valid = 0; issue_valid = 0; issue_is_load = 0;
        rst_n = 1'b0;
        #1;
        chk("t6_w_en", rf_w_en, 0);
        chk("t6_rda", rf_rda, 0);
        chk("t6_rd", rf_rd, 0);
        chk("t6_busy", busy, 0);
        chk("t6_alu_ready", alu_ready, 0);
        chk("t6_lsu_ready", lsu_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        idle(4);

        // Random traffic with alternating ALU pressure
        pa_v = 0; pl_v = 0; pa_rd = 0; pl_rd = 0; pa_d = 0; pl_d = 0;
        for (int k = 0; k < 2500; k++) begin
            apct = ((k / 500) % 2 == 1) ? 95 : 40;
            if (!(pa_v && !last_alu_acc)) begin
                pa_v = ($urandom_range(0, 99) < apct);
                pa_rd = 5'($urandom_range(0, 31));
                pa_d = $urandom;
            end
            if (!(pl_v && !last_lsu_acc)) begin
                pl_v = 0;
                if (outq.size() > 0 && $urandom_range(0, 99) < 50) begin
                    idx = $urandom_range(0, outq.size() - 1);
                    pl_rd = outq[idx];
                    outq.delete(idx);
                    pl_v = 1;
                    pl_d = $urandom;
                end
            end
            iv = ($urandom_range(0, 99) < 40);
            il = ($urandom_range(0, 99) < 60) && (outq.size() < 8);
            ird = 5'($urandom_range(0, 31));
            if (ird != 0 && m_busy[ird]) il = 0;
            if (iv && il) outq.push_back(ird);
            step(pa_v, pa_rd, pa_d, pl_v, pl_rd, pl_d, iv, il, ird);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
